// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lane gate arbiter.
// Pure definitions, no logic.
package parking_pkg;
   localparam int OCC_W        = 5;
   localparam int TMR_W        = 8;
   localparam int DEF_CAPACITY = 25;
   localparam int DEF_TIMEOUT  = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_OPEN  = 2'd1,
      OUT_OPEN = 2'd2,
      CLOSE    = 2'd3
   } state_t;

   typedef enum logic {
      DIR_IN  = 1'b0,
      DIR_OUT = 1'b1
   } dir_t;
endpackage

// File: rtl/parking_lane_arbiter_gate_timer.sv
// Open-cycle timer: clear wins over enable, saturates at TIMEOUT-1 where done is high.
// Count is registered; done is decoded from it in the same cycle; no backpressure.
module gate_timer
   import parking_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_done
);
   logic [TMR_W-1:0] r_count;
   logic             w_done;

   assign w_done = (r_count == TMR_W'(TIMEOUT - 1));
   assign o_done = w_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_done) begin
         r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/parking_lane_arbiter.sv
// Entry/exit gate arbiter with occupancy count; grant one cycle after the request is sampled.
// Ineligible requests (full/empty) stay pending; a new grant never issues during CLOSE.
module parking_lane_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY = DEF_CAPACITY,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_in,
   input  logic             req_out,
   input  logic             car_entered,
   input  logic             car_exited,
   output logic             gate_in_open,
   output logic             gate_out_open,
   output logic             grant_in,
   output logic             grant_out,
   output logic             inc,
   output logic             dec,
   output logic [OCC_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             busy,
   output logic             timeout_err
);
   state_t           r_state;
   dir_t             r_last;
   logic             r_armed;
   logic [OCC_W-1:0] r_occ;
   logic             r_gate_in;
   logic             r_gate_out;
   logic             r_grant_in;
   logic             r_grant_out;
   logic             r_inc;
   logic             r_dec;
   logic             r_tmo;
   logic             r_busy;

   logic             w_full;
   logic             w_empty;
   logic             w_elig_in;
   logic             w_elig_out;
   logic             w_arb;
   logic             w_pick_in;
   logic             w_pick_out;
   logic             w_grant;
   logic             w_open;
   logic             w_tmr_done;

   assign w_full     = (r_occ == OCC_W'(CAPACITY));
   assign w_empty    = (r_occ == '0);
   assign w_elig_in  = req_in  & ~w_full;
   assign w_elig_out = req_out & ~w_empty;

   // r_armed keeps the first edge after reset release from granting.
   assign w_arb      = (r_state == IDLE) & r_armed;
   assign w_pick_in  = w_arb & w_elig_in  & (~w_elig_out | (r_last == DIR_OUT));
   assign w_pick_out = w_arb & w_elig_out & (~w_elig_in  | (r_last == DIR_IN));
   assign w_grant    = w_pick_in | w_pick_out;
   assign w_open     = (r_state == IN_OPEN) | (r_state == OUT_OPEN);

   gate_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_grant),
      .i_enable (w_open),
      .o_done   (w_tmr_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_last      <= DIR_OUT;
         r_armed     <= 1'b0;
         r_occ       <= '0;
         r_gate_in   <= 1'b0;
         r_gate_out  <= 1'b0;
         r_grant_in  <= 1'b0;
         r_grant_out <= 1'b0;
         r_inc       <= 1'b0;
         r_dec       <= 1'b0;
         r_tmo       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_armed     <= 1'b1;
         r_grant_in  <= 1'b0;
         r_grant_out <= 1'b0;
         r_inc       <= 1'b0;
         r_dec       <= 1'b0;
         r_tmo       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_in) begin
                  r_state    <= IN_OPEN;
                  r_gate_in  <= 1'b1;
                  r_grant_in <= 1'b1;
                  r_last     <= DIR_IN;
                  r_busy     <= 1'b1;
               end else if (w_pick_out) begin
                  r_state     <= OUT_OPEN;
                  r_gate_out  <= 1'b1;
                  r_grant_out <= 1'b1;
                  r_last      <= DIR_OUT;
                  r_busy      <= 1'b1;
               end
            end
            // A pass on the final timer cycle wins over the timeout.
            IN_OPEN: begin
               if (car_entered) begin
                  r_state   <= CLOSE;
                  r_gate_in <= 1'b0;
                  r_inc     <= 1'b1;
                  r_occ     <= r_occ + 1'b1;
               end else if (w_tmr_done) begin
                  r_state   <= CLOSE;
                  r_gate_in <= 1'b0;
                  r_tmo     <= 1'b1;
               end
            end
            OUT_OPEN: begin
               if (car_exited) begin
                  r_state    <= CLOSE;
                  r_gate_out <= 1'b0;
                  r_dec      <= 1'b1;
                  r_occ      <= r_occ - 1'b1;
               end else if (w_tmr_done) begin
                  r_state    <= CLOSE;
                  r_gate_out <= 1'b0;
                  r_tmo      <= 1'b1;
               end
            end
            CLOSE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= IDLE;
               r_gate_in  <= 1'b0;
               r_gate_out <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign gate_in_open  = r_gate_in;
   assign gate_out_open = r_gate_out;
   assign grant_in      = r_grant_in;
   assign grant_out     = r_grant_out;
   assign inc           = r_inc;
   assign dec           = r_dec;
   assign occupancy     = r_occ;
   assign full          = w_full;
   assign empty         = w_empty;
   assign busy          = r_busy;
   assign timeout_err   = r_tmo;
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter with CAPACITY=4, TIMEOUT=8.
module tb_parking_lane_arbiter;
   logic       clk;
   logic       reset;
   logic       req_in;
   logic       req_out;
   logic       car_entered;
   logic       car_exited;
   logic       gate_in_open;
   logic       gate_out_open;
   logic       grant_in;
   logic       grant_out;
   logic       inc;
   logic       dec;
   logic [4:0] occupancy;
   logic       full;
   logic       empty;
   logic       busy;
   logic       timeout_err;

   int n_total = 0;
   int n_bad   = 0;

   parking_lane_arbiter #(
      .CAPACITY (4),
      .TIMEOUT  (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_in        (req_in),
      .req_out       (req_out),
      .car_entered   (car_entered),
      .car_exited    (car_exited),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .grant_in      (grant_in),
      .grant_out     (grant_out),
      .inc           (inc),
      .dec           (dec),
      .occupancy     (occupancy),
      .full          (full),
      .empty         (empty),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in IDLE with the request for d_in already held; completes one pass.
   task automatic run_xact(input bit d_in, input int occ_exp);
      tick();
      check(d_in ? "grant_in" : "grant_out", d_in ? grant_in : grant_out, 1);
      check(d_in ? "gate_in" : "gate_out", d_in ? gate_in_open : gate_out_open, 1);
      check("grant_other", d_in ? grant_out : grant_in, 0);
      if (d_in) req_in = 1'b0; else req_out = 1'b0;
      tick();
      check("grant_one_cycle", d_in ? grant_in : grant_out, 0);
      check("gate_held", d_in ? gate_in_open : gate_out_open, 1);
      if (d_in) car_entered = 1'b1; else car_exited = 1'b1;
      tick();
      car_entered = 1'b0;
      car_exited  = 1'b0;
      check(d_in ? "inc_pulse" : "dec_pulse", d_in ? inc : dec, 1);
      check("occ_after_pass", occupancy, occ_exp);
      check("gate_closed", gate_in_open | gate_out_open, 0);
      check("busy_close", busy, 1);
      tick();
      check("step_one_cycle", inc | dec, 0);
      check("idle_after_close", busy, 0);
      check("occ_stable", occupancy, occ_exp);
   endtask

   task automatic no_grant(input int n);
      repeat (n) begin
         tick();
         check("no_grant", grant_in | grant_out | busy, 0);
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b0;
      req_in = 1'b0;
      req_out = 1'b0;
      car_entered = 1'b0;
      car_exited = 1'b0;
      #12;
      check("rst_occ", occupancy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_gates", gate_in_open | gate_out_open, 0);
      check("rst_pulses", grant_in | grant_out | inc | dec | timeout_err, 0);

      // Release with req_in held: first edge must not grant.
      tick();
      reset  = 1'b1;
      req_in = 1'b1;
      tick();
      check("first_edge_no_grant", grant_in, 0);
      run_xact(1'b1, 1);
      req_out = 1'b1;
      run_xact(1'b0, 0);
      check("empty_after_exit", empty, 1);

      req_out = 1'b1;
      no_grant(10);
      req_out = 1'b0;

      for (int i = 0; i < 4; i++) begin
         req_in = 1'b1;
         run_xact(1'b1, i + 1);
      end
      check("full_at_cap", full, 1);
      req_in = 1'b1;
      no_grant(10);
      req_out = 1'b1;
      run_xact(1'b0, 3);
      req_in = 1'b0;

      // Ties at occupancy 3 with last grant out, then with last grant in.
      req_in = 1'b1;
      req_out = 1'b1;
      run_xact(1'b1, 4);
      run_xact(1'b0, 3);
      req_in = 1'b1;
      req_out = 1'b1;
      run_xact(1'b1, 4);
      run_xact(1'b0, 3);
      req_out = 1'b1;
      run_xact(1'b0, 2);
      req_in = 1'b1;
      run_xact(1'b1, 3);
      req_in = 1'b1;
      req_out = 1'b1;
      run_xact(1'b0, 2);
      run_xact(1'b1, 3);

      // Timeout with a wrong-direction pulse in the middle.
      req_in = 1'b1;
      tick();
      check("tmo_grant", grant_in, 1);
      req_in = 1'b0;
      cnt = 1;
      for (int k = 0; k < 20; k++) begin
         car_exited = (cnt == 3);
         tick();
         if (gate_in_open) cnt++;
         else break;
      end
      car_exited = 1'b0;
      check("tmo_gate_cycles", cnt, 8);
      check("tmo_err", timeout_err, 1);
      check("tmo_occ", occupancy, 3);
      check("tmo_no_step", inc | dec, 0);
      tick();
      check("tmo_err_one_cycle", timeout_err, 0);
      check("tmo_idle", busy, 0);

      // Pass on the last timer cycle wins.
      req_in = 1'b1;
      tick();
      check("coin_grant", grant_in, 1);
      req_in = 1'b0;
      repeat (7) tick();
      check("coin_gate_last", gate_in_open, 1);
      car_entered = 1'b1;
      tick();
      car_entered = 1'b0;
      check("coin_inc", inc, 1);
      check("coin_no_tmo", timeout_err, 0);
      check("coin_occ", occupancy, 4);
      tick();

      // Reset in the middle of OUT_OPEN.
      req_out = 1'b1;
      tick();
      check("mid_grant_out", grant_out, 1);
      req_out = 1'b0;
      tick();
      check("mid_gate_out", gate_out_open, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_gate", gate_out_open, 0);
      check("mid_rst_occ", occupancy, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_dec", dec, 0);
      check("mid_rst_busy", busy, 0);
      tick();
      check("mid_rst_dec_edge", dec, 0);
      req_in = 1'b1;
      reset  = 1'b1;
      tick();
      check("rel_first_edge", grant_in, 0);
      tick();
      check("rel_second_edge", grant_in, 1);
      req_in = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end
endmodule

// File: doc/parking_lane_arbiter.md
PARKING_LANE_ARBITER -- requirements
Module: parking_lane_arbiter

Interface
REQ-001 SHALL have parameter CAPACITY, default 25, the maximum occupancy; legal range 1..31.
REQ-002 SHALL have parameter TIMEOUT, default 8, the number of gate-open cycles allowed before abort; legal range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, an asynchronous, active-low reset.
REQ-005 SHALL have port req_in, input, 1, an entry request; level, held by the requester.
REQ-006 SHALL have port req_out, input, 1, an exit request; level, held by the requester.
REQ-007 SHALL have port car_entered, input, 1, a one-cycle pass pulse from the sensor FSM in the entry direction.
REQ-008 SHALL have port car_exited, input, 1, a one-cycle pass pulse from the sensor FSM in the exit direction.
REQ-009 SHALL have port gate_in_open, output, 1, which is high while the entry gate is open.
REQ-010 SHALL have port gate_out_open, output, 1, which is high while the exit gate is open.
REQ-011 SHALL have ports grant_in and grant_out, output, 1 each, as one-cycle grant pulses.
REQ-012 SHALL have ports inc and dec, output, 1 each, as one-cycle pulses to the occupancy counter.
REQ-013 SHALL have port occupancy, output, 5, the current car count.
REQ-014 SHALL have ports full, empty, busy and timeout_err, output, 1 each.

Function
REQ-015 SHALL make all outputs registered.
REQ-016 SHALL implement FSM states IDLE, IN_OPEN, OUT_OPEN and CLOSE.
REQ-017 SHALL, in IDLE:
- treat req_in as eligible only when full=0;
- treat req_out as eligible only when empty=0;
- leave ineligible requests pending without acknowledgement.
REQ-018 SHALL, in IDLE with exactly one eligible request, enter IN_OPEN or OUT_OPEN on the next edge.
REQ-019 SHALL arbitrate round-robin when both requests are eligible in the same cycle:
- grant the direction opposite to last_grant;
- update last_grant on each grant.
REQ-020 SHALL assert grant_x for exactly the first cycle of the X_OPEN state, one cycle after the request is sampled.
REQ-021 SHALL hold gate_x_open high for every cycle spent in X_OPEN.
REQ-022 SHALL, in IN_OPEN, on car_entered=1, go to CLOSE and, in the next cycle only, have inc=1 and occupancy+1.
REQ-023 SHALL, in OUT_OPEN, on car_exited=1, go to CLOSE and, in the next cycle only, have dec=1 and occupancy-1.
REQ-024 SHALL count open cycles with a timer cleared on grant.
REQ-025 SHALL, when the timer reaches TIMEOUT-1 with no pass, go to CLOSE and pulse timeout_err for one cycle with no occupancy change.
REQ-026 SHALL give the pass priority when a pass pulse and the timeout coincide on the same cycle.
REQ-027 SHALL ignore a wrong-direction pulse while a gate is open (car_exited in IN_OPEN, car_entered in OUT_OPEN).
REQ-028 SHALL ignore any pass pulse received in IDLE or CLOSE.
REQ-029 SHALL stay in CLOSE for exactly one cycle with both gates low, then return to IDLE.
REQ-030 SHALL NOT grant a new request during CLOSE, so grants are at least 2 cycles apart.
REQ-031 SHALL define full as occupancy==CAPACITY and empty as occupancy==0, both combinationally decoded from the occupancy register.
REQ-032 SHALL never let occupancy wrap, because the full and empty gating prevents it.
REQ-033 SHALL drive busy=1 in any state other than IDLE.

Reset
REQ-034 SHALL, on reset=0, immediately force:
- state to IDLE;
- occupancy, timer, both gate outputs, grants, inc, dec and timeout_err to 0;
- empty to 1, full to 0, busy to 0;
- last_grant to "out", so the first tie goes to entry.
REQ-035 SHALL, on reset asserted while a gate is open, close the gate asynchronously and emit no inc or dec pulse.
REQ-036 SHALL NOT grant on the first rising edge after reset deasserts; arbitration is sampled from the second edge onward.

Structure
REQ-037 SHALL place the following in the shared package parking_pkg:
- the state enum;
- OCC_W=5;
- default CAPACITY and TIMEOUT.
REQ-038 SHALL implement the open-cycle timer as the sub-module gate_timer, with clear and enable inputs and a done output, reset by the same asynchronous active-low reset.
REQ-039 SHALL have an RTL implementation of about 150-250 lines.

Verification
REQ-040 SHALL verify basic entry and exit: hold req_in; expect grant_in and gate_in_open 1 cycle later; pulse car_entered; then expect inc=1 and occupancy 0->1, one CLOSE cycle, then IDLE. Repeat for exit, with occupancy 1->0 and empty=1.
REQ-041 SHALL verify the tie: occupancy=3, req_in and req_out raised on the same cycle from reset; expect grant_in first, then grant_out after completion, then grant_in on the next tie.
REQ-042 SHALL verify the boundaries: with CAPACITY=4, after 4 entries expect full=1, req_in producing no grant for 10 cycles, and req_out still granted. From empty, req_out produces no grant.
REQ-043 SHALL verify the timeout: with TIMEOUT=8, grant_in with no pass; expect gate_in_open high for exactly 8 cycles, a timeout_err pulse, occupancy unchanged, and a wrong-direction car_exited ignored.
REQ-044 SHALL verify the coincidence: car_entered on timer cycle TIMEOUT-1; expect inc=1, no timeout_err, occupancy+1.
REQ-045 SHALL verify reset mid-operation: assert reset in the middle of OUT_OPEN; expect gate_out_open=0 immediately, occupancy=0, empty=1, no dec, and no grant on the first edge after release.
